// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, FSM states and
// the byte-enable helper.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Byte enables for a 64-bit lane group; the offset is truncated to natural alignment.
    function automatic logic [7:0] be_for(input logic [1:0] size, input logic [2:0] addr);
        logic [7:0] ones;
        logic [2:0] off;
        unique case (size)
            SZ_B:    begin ones = 8'h01; off = addr;                end
            SZ_H:    begin ones = 8'h03; off = addr & 3'b110;       end
            SZ_W:    begin ones = 8'h0F; off = addr & 3'b100;       end
            default: begin ones = 8'hFF; off = 3'b000;              end
        endcase
        return ones << off;
    endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory request/acknowledge bus.
//   master: stage side (drives request, address, write data, byte enables)
//   slave : memory side (returns read data and acknowledge)
interface mem_stage_hs_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_be;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  dm_ack;

    modport master (output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
                    input  dm_rdata, dm_ack);
    modport slave  (input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
                    output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: aligned address, byte enables, store-data replication,
// load lane extraction with sign/zero extension and misalignment detection.
// Ports: size/is_unsigned/addr/wdata/rdata in; addr_c/be_c/wdata_c/rdata_c/misalign_c out.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic [1:0]          size,
    input  logic                is_unsigned,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   addr_c,
    output logic [DATA_W/8-1:0] be_c,
    output logic [DATA_W-1:0]   wdata_c,
    output logic [DATA_W-1:0]   rdata_c,
    output logic                misalign_c
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = (DATA_W == 64) ? 3 : 2;

    logic [1:0]        size_eff;
    logic [2:0]        off3;
    logic [2:0]        size_mask;
    logic [2:0]        off_al;
    logic [7:0]        be8;
    logic [DATA_W-1:0] sh;
    logic              sign;
    int unsigned       nbits;

    // A 32-bit datapath has no doubleword; treat it as a word.
    assign size_eff = (DATA_W == 32 && size == SZ_D) ? SZ_W : size;
    assign off3     = 3'(addr[LB-1:0]);
    assign addr_c   = {addr[ADDR_W-1:LB], {LB{1'b0}}};
    assign be8      = be_for(size_eff, off3);
    assign be_c     = be8[NB-1:0];

    always_comb begin
        unique case (size_eff)
            SZ_B:    size_mask = 3'b000;
            SZ_H:    size_mask = 3'b001;
            SZ_W:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    end

    assign misalign_c = |(off3 & size_mask);
    assign off_al     = off3 & ~size_mask;

    // Store data copied into every lane group of the access size.
    always_comb begin
        wdata_c = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            unique case (size_eff)
                SZ_B:    wdata_c[8*i +: 8] = wdata[7:0];
                SZ_H:    wdata_c[8*i +: 8] = wdata[8*(i%2) +: 8];
                SZ_W:    wdata_c[8*i +: 8] = wdata[8*(i%4) +: 8];
                default: wdata_c[8*i +: 8] = wdata[8*i +: 8];
            endcase
        end
    end

    // Shift the addressed lane down to bit 0, then extend above the access width.
    always_comb begin
        sh    = rdata >> {off_al, 3'b000};
        nbits = 32'd8 << size_eff;
        unique case (size_eff)
            SZ_B:    sign = sh[7];
            SZ_H:    sign = sh[15];
            SZ_W:    sign = sh[31];
            default: sign = sh[DATA_W-1];
        endcase
        sign    = sign & ~is_unsigned;
        rdata_c = '0;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            rdata_c[j] = (j < nbits) ? sh[j] : sign;
        end
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with req/ack data-memory handshake, stall generation and the
// registered MEM/WB boundary.
// Ports: clk, rst (async active-low); ex_* EX/MEM inputs; mem_stall; dm (memory bus,
// master side); wb_* registered MEM/WB outputs.
// Build option: MEM_MISALIGN_TRAP_EN makes misaligned accesses complete without a
// memory request and raise wb_misalign; otherwise the low address bits are truncated.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_reg_write,
    input  logic [1:0]            ex_size,
    input  logic                  ex_unsigned,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     ex_write_data,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  mem_stall,
    mem_stage_hs_if.master        dm,
    output logic                  wb_valid,
    output logic                  wb_mem_to_reg,
    output logic                  wb_reg_write,
    output logic [DATA_W-1:0]     wb_read_data,
    output logic [DATA_W-1:0]     wb_alu_result,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic                  wb_misalign
);
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [DATA_W-1:0]     wb_read_data_q, wb_read_data_d;
    logic [DATA_W-1:0]     wb_alu_result_q, wb_alu_result_d;
    logic [REG_ADDR_W-1:0] wb_write_reg_q, wb_write_reg_d;
    logic                  wb_misalign_q, wb_misalign_d;

    logic                  mem_op, trap, req, stall, load_wb, req_on;
    logic [ADDR_W-1:0]     addr_c;
    logic [DATA_W/8-1:0]   be_c;
    logic [DATA_W-1:0]     wdata_c, rdata_c;
    logic                  misalign_c;

    mem_lane_align #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_align (
        .size        (ex_size),
        .is_unsigned (ex_unsigned),
        .addr        (ADDR_W'(ex_alu_result)),
        .wdata       (ex_write_data),
        .rdata       (dm.dm_rdata),
        .addr_c      (addr_c),
        .be_c        (be_c),
        .wdata_c     (wdata_c),
        .rdata_c     (rdata_c),
        .misalign_c  (misalign_c)
    );

    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
    assign trap   = TRAP_EN & mem_op & misalign_c;

    // Next state, request/stall, and MEM/WB register inputs (bubble by default).
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        load_wb = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_op && !trap) begin
                    req = 1'b1;
                    if (dm.dm_ack) begin
                        load_wb = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else begin
                    load_wb = 1'b1;
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (dm.dm_ack) begin
                    load_wb = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wb_valid_d      = 1'b0;
        wb_mem_to_reg_d = 1'b0;
        wb_reg_write_d  = 1'b0;
        wb_read_data_d  = '0;
        wb_alu_result_d = '0;
        wb_write_reg_d  = '0;
        wb_misalign_d   = 1'b0;
        if (load_wb) begin
            wb_valid_d      = ex_valid;
            wb_mem_to_reg_d = ex_mem_to_reg;
            wb_reg_write_d  = ex_valid & ex_reg_write & ~trap;
            wb_alu_result_d = ex_alu_result;
            wb_write_reg_d  = ex_write_reg;
            wb_misalign_d   = trap;
            // Read+write together is a store, so no load data is returned.
            if (mem_op && ex_mem_read && !ex_mem_write && !trap) begin
                wb_read_data_d = rdata_c;
            end
        end
    end

    // State and MEM/WB registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            wb_valid_q      <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= '0;
            wb_write_reg_q  <= '0;
            wb_misalign_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            wb_valid_q      <= wb_valid_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_write_reg_q  <= wb_write_reg_d;
            wb_misalign_q   <= wb_misalign_d;
        end
    end

    // Bus and stall are combinational; all are held at 0 while reset is asserted.
    assign req_on      = req & rst;
    assign mem_stall   = stall & rst;
    assign dm.dm_req   = req_on;
    assign dm.dm_we    = req_on & ex_mem_write;
    assign dm.dm_addr  = req_on ? addr_c  : '0;
    assign dm.dm_wdata = (req_on && ex_mem_write) ? wdata_c : '0;
    assign dm.dm_be    = req_on ? be_c    : '0;

    assign wb_valid      = wb_valid_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_misalign   = wb_misalign_q;

endmodule
